// File: rtl/qspi_ram_responder.sv
// QPI RAM target: oversamples the initiator's bus on clk, decodes 0xEB/0x38
// commands and serves byte bursts from an internal array.
module qspi_ram_responder #(
    parameter int DEPTH = 256,
    parameter int DUMMY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ram_clk,
    input  logic       ram_csn,
    input  logic [3:0] ram_io_i,
    output logic [3:0] ram_io_o,
    output logic [3:0] ram_io_oe,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] DUM_LAST = 8'(DUMMY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
    } state_t;

    // Bit 2 of the clock chain is the edge-detect history, not a sync stage.
    logic [2:0] sclk_q;
    logic [1:0] scsn_q;
    logic [3:0] sio1_q, sio2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            scsn_q <= 2'b11;
            sio1_q <= 4'h0;
            sio2_q <= 4'h0;
        end else begin
            sclk_q <= {sclk_q[1:0], ram_clk};
            scsn_q <= {scsn_q[0], ram_csn};
            sio1_q <= ram_io_i;
            sio2_q <= sio1_q;
        end
    end

    logic       rise, fall, csn_s;
    logic [3:0] io_s;
    assign rise  = sclk_q[1] & ~sclk_q[2];
    assign fall  = ~sclk_q[1] & sclk_q[2];
    assign csn_s = scsn_q[1];
    assign io_s  = sio2_q;

    logic [7:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  hi_q, hi_d;
    logic        nib_q, nib_d;
    logic [3:0]  out_q, out_d;
    logic        oe_q, oe_d;
    logic        mem_we;
    logic [7:0]  mem_wd, rd_byte;

    assign rd_byte = mem[addr_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        nib_d   = nib_q;
        out_d   = out_q;
        oe_d    = oe_q;
        mem_we  = 1'b0;
        mem_wd  = {hi_q, io_s};
        // Deselect outranks any clock edge seen in the same cycle.
        if (csn_s) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            nib_d   = 1'b0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    cnt_d   = 8'd0;
                end
                S_CMD: if (rise) begin
                    cmd_d = {cmd_q[3:0], io_s};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = (cmd_d == 8'hEB || cmd_d == 8'h38) ? S_ADDR : S_IGNORE;
                    end
                end
                S_ADDR: if (rise) begin
                    addr_d = {addr_q[19:0], io_s};
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'd5) begin
                        cnt_d = 8'd0;
                        nib_d = 1'b0;
                        if (cmd_q == 8'h38)  state_d = S_WRITE;
                        else if (DUMMY == 0) state_d = S_READ;
                        else                 state_d = S_DUMMY;
                    end
                end
                S_DUMMY: if (rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == DUM_LAST) state_d = S_READ;
                end
                S_READ: begin
                    if (fall) begin
                        out_d = nib_q ? rd_byte[3:0] : rd_byte[7:4];
                        oe_d  = 1'b1;
                    end else if (rise) begin
                        // Advance only once the low nibble has been sampled.
                        nib_d = ~nib_q;
                        if (nib_q) addr_d = addr_q + 24'd1;
                    end
                end
                S_WRITE: if (rise) begin
                    if (!nib_q) begin
                        hi_d  = io_s;
                        nib_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        addr_d = addr_q + 24'd1;
                        nib_d  = 1'b0;
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cmd_q   <= 8'd0;
            addr_q  <= 24'd0;
            hi_q    <= 4'h0;
            nib_q   <= 1'b0;
            out_q   <= 4'h0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            nib_q   <= nib_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    // Storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= mem_wd;
    end

    assign ram_io_o  = out_q;
    assign ram_io_oe = {4{oe_q}};
    assign busy      = (state_q != S_IDLE);
endmodule
